// File: rtl/game_pkg.sv
// Shared types and constants for the fruit-slicing game logic.
// Used by the per-frame ball update scheduler and its shared MAC.
package game_pkg;

  localparam int N_BALL  = 4;
  localparam int COORD_W = 11;
  localparam int VEL_W   = 6;
  localparam int HIT_R2  = 900;
  localparam int FLOOR_Y = 639;
  localparam int GRAVITY = 1;
  localparam int IDX_W   = $clog2(N_BALL);
  localparam int ACC_W   = 2 * COORD_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SQX,
    SQY,
    DECIDE,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic               active;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [VEL_W-1:0]   vx;
    logic [VEL_W-1:0]   vy;
  } ball_t;

  function automatic logic [COORD_W-1:0] abs_diff(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sq_dist_mac.sv
// Single squarer with accumulator; clr loads op^2, acc_en adds op^2.
// The scheduler time-shares it for dx^2 then dy^2.
module sq_dist_mac
  import game_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               clr,
  input  logic               acc_en,
  input  logic [COORD_W-1:0] op,
  output logic [ACC_W-1:0]   acc
);

  logic [2*COORD_W-1:0] prod;

  assign prod = op * op;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= ACC_W'(prod);
    end else if (acc_en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/ball_update_sched.sv
// Per-frame ball sweep: hit test against the latched hand, then
// kill or integrate each active slot through one shared MAC.
module ball_update_sched
  import game_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_end,
  input  logic               i_hand_valid,
  input  logic [COORD_W-1:0] i_hand_x,
  input  logic [COORD_W-1:0] i_hand_y,
  output logic [IDX_W-1:0]   o_rd_idx,
  input  logic               i_ball_active,
  input  logic [COORD_W-1:0] i_ball_x,
  input  logic [COORD_W-1:0] i_ball_y,
  input  logic [VEL_W-1:0]   i_ball_vx,
  input  logic [VEL_W-1:0]   i_ball_vy,
  output logic               o_wr_en,
  output logic [IDX_W-1:0]   o_wr_idx,
  output logic               o_wr_kill,
  output logic [COORD_W-1:0] o_wr_x,
  output logic [COORD_W-1:0] o_wr_y,
  output logic [VEL_W-1:0]   o_wr_vy,
  output logic               o_hit,
  output logic               o_miss,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overrun
);

  sched_state_t       state;
  logic [IDX_W-1:0]   idx;
  ball_t              ball;
  logic               hv;
  logic [COORD_W-1:0] hx;
  logic [COORD_W-1:0] hy;
  logic [COORD_W-1:0] adx;
  logic [COORD_W-1:0] ady;

  logic               mac_clr;
  logic               mac_acc;
  logic [COORD_W-1:0] mac_op;
  logic [ACC_W-1:0]   acc;

  logic               last;
  logic               hit;
  logic               off;
  logic               vy_neg;
  logic               miss;
  logic               ceil;
  logic [COORD_W-1:0] x_n;
  logic [COORD_W-1:0] y_n;
  logic [VEL_W:0]     vy_sum;
  logic [VEL_W-1:0]   vy_n;

  assign o_rd_idx = idx;
  assign last     = (idx == IDX_W'(N_BALL - 1));

  assign mac_clr = (state == SQX);
  assign mac_acc = (state == SQY);
  assign mac_op  = (state == SQY) ? ady : adx;

  sq_dist_mac u_mac (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr     (mac_clr),
    .acc_en  (mac_acc),
    .op      (mac_op),
    .acc     (acc)
  );

  // Outcome of the slot held in DECIDE; priority is hit, miss, ceiling.
  always_comb begin
    hit    = hv && ball.active && (acc <= ACC_W'(HIT_R2));
    x_n    = ball.x + {{(COORD_W-VEL_W){ball.vx[VEL_W-1]}}, ball.vx};
    y_n    = ball.y + {{(COORD_W-VEL_W){ball.vy[VEL_W-1]}}, ball.vy};
    vy_neg = ball.vy[VEL_W-1];
    vy_sum = {ball.vy[VEL_W-1], ball.vy} + (VEL_W+1)'(GRAVITY);
    vy_n   = vy_sum[VEL_W-1:0];
    if (!vy_neg && vy_sum[VEL_W-1]) begin
      vy_n = {1'b0, {(VEL_W-1){1'b1}}};
    end
    off  = (y_n > COORD_W'(FLOOR_Y));
    miss = !hit && off && !vy_neg;
    ceil = !hit && off && vy_neg;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      ball      <= '0;
      hv        <= 1'b0;
      hx        <= '0;
      hy        <= '0;
      adx       <= '0;
      ady       <= '0;
      o_wr_en   <= 1'b0;
      o_wr_idx  <= '0;
      o_wr_kill <= 1'b0;
      o_wr_x    <= '0;
      o_wr_y    <= '0;
      o_wr_vy   <= '0;
      o_hit     <= 1'b0;
      o_miss    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_wr_en   <= 1'b0;
      o_wr_kill <= 1'b0;
      o_hit     <= 1'b0;
      o_miss    <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= i_frame_end && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (i_frame_end) begin
            hv     <= i_hand_valid;
            hx     <= i_hand_x;
            hy     <= i_hand_y;
            idx    <= '0;
            o_busy <= 1'b1;
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (!i_ball_active) begin
            if (last) state <= DONE;
            else      idx   <= idx + 1'b1;
          end else begin
            ball  <= '{active: 1'b1, x: i_ball_x, y: i_ball_y,
                       vx: i_ball_vx, vy: i_ball_vy};
            adx   <= abs_diff(hx, i_ball_x);
            ady   <= abs_diff(hy, i_ball_y);
            state <= SQX;
          end
        end
        SQX: state <= SQY;
        SQY: state <= DECIDE;
        DECIDE: begin
          o_wr_en  <= 1'b1;
          o_wr_idx <= idx;
          o_wr_x   <= x_n;
          o_wr_y   <= y_n;
          o_wr_vy  <= vy_n;
          unique case (1'b1)
            hit: begin
              o_wr_kill <= 1'b1;
              o_hit     <= 1'b1;
            end
            miss: begin
              o_wr_kill <= 1'b1;
              o_miss    <= 1'b1;
            end
            ceil: begin
              o_wr_y  <= '0;
              o_wr_vy <= '0;
            end
            default: ;
          endcase
          if (last) begin
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= FETCH;
          end
        end
        DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_update_sched.sv
// Scenario bench for ball_update_sched with a write-back scoreboard.
// Expected slot results come from an integer model of the game rules.
module tb_ball_update_sched;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_frame_end = 1'b0;
  logic        i_hand_valid = 1'b0;
  logic [10:0] i_hand_x = '0;
  logic [10:0] i_hand_y = '0;
  logic [1:0]  o_rd_idx;
  logic        i_ball_active;
  logic [10:0] i_ball_x;
  logic [10:0] i_ball_y;
  logic [5:0]  i_ball_vx;
  logic [5:0]  i_ball_vy;
  logic        o_wr_en;
  logic [1:0]  o_wr_idx;
  logic        o_wr_kill;
  logic [10:0] o_wr_x;
  logic [10:0] o_wr_y;
  logic [5:0]  o_wr_vy;
  logic        o_hit;
  logic        o_miss;
  logic        o_busy;
  logic        o_done;
  logic        o_overrun;

  logic        act [4];
  logic [10:0] bx  [4];
  logic [10:0] by  [4];
  logic [5:0]  bvx [4];
  logic [5:0]  bvy [4];

  assign i_ball_active = act[o_rd_idx];
  assign i_ball_x      = bx[o_rd_idx];
  assign i_ball_y      = by[o_rd_idx];
  assign i_ball_vx     = bvx[o_rd_idx];
  assign i_ball_vy     = bvy[o_rd_idx];

  ball_update_sched dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_frame_end   (i_frame_end),
    .i_hand_valid  (i_hand_valid),
    .i_hand_x      (i_hand_x),
    .i_hand_y      (i_hand_y),
    .o_rd_idx      (o_rd_idx),
    .i_ball_active (i_ball_active),
    .i_ball_x      (i_ball_x),
    .i_ball_y      (i_ball_y),
    .i_ball_vx     (i_ball_vx),
    .i_ball_vy     (i_ball_vy),
    .o_wr_en       (o_wr_en),
    .o_wr_idx      (o_wr_idx),
    .o_wr_kill     (o_wr_kill),
    .o_wr_x        (o_wr_x),
    .o_wr_y        (o_wr_y),
    .o_wr_vy       (o_wr_vy),
    .o_hit         (o_hit),
    .o_miss        (o_miss),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_overrun     (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int idx;
    bit kill;
    int x;
    int y;
    int vy;
    bit hit;
    bit miss;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  ovr_cnt = 0;
  int  stray_cnt = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_wr_en) begin
      wr_t o;
      o.idx  = int'(o_wr_idx);
      o.kill = o_wr_kill;
      o.x    = int'(o_wr_x);
      o.y    = int'(o_wr_y);
      o.vy   = int'($signed(o_wr_vy));
      o.hit  = o_hit;
      o.miss = o_miss;
      obs_q.push_back(o);
    end
    if ((o_hit || o_miss) && !o_wr_en) stray_cnt++;
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (o_overrun) ovr_cnt++;
  end

  function automatic wr_t model(input int i, input bit hv,
                                input int hx, input int hy);
    wr_t r;
    int dx, dy, vx, vy, xn, yn;
    dx = hx - int'(bx[i]);
    dy = hy - int'(by[i]);
    vx = int'($signed(bvx[i]));
    vy = int'($signed(bvy[i]));
    r.idx = i; r.kill = 0; r.hit = 0; r.miss = 0;
    r.x = 0; r.y = 0; r.vy = 0;
    if (hv && (dx*dx + dy*dy <= 900)) begin
      r.kill = 1; r.hit = 1;
      return r;
    end
    xn = (int'(bx[i]) + vx) & 2047;
    yn = (int'(by[i]) + vy) & 2047;
    r.x = xn;
    if (yn > 639 && vy >= 0) begin
      r.kill = 1; r.miss = 1;
    end else if (yn > 639) begin
      r.y = 0; r.vy = 0;
    end else begin
      r.y = yn;
      r.vy = (vy + 1 > 31) ? 31 : vy + 1;
    end
    return r;
  endfunction

  task automatic set_ball(input int i, input bit a, input int x,
                          input int y, input int vx, input int vy);
    act[i] = a;
    bx[i]  = 11'(x);
    by[i]  = 11'(y);
    bvx[i] = 6'(vx);
    bvy[i] = 6'(vy);
  endtask

  task automatic clear_balls();
    for (int i = 0; i < 4; i++) set_ball(i, 0, 0, 0, 0, 0);
  endtask

  function automatic int exp_lat();
    int l = 1;
    for (int i = 0; i < 4; i++) l += act[i] ? 4 : 1;
    return l;
  endfunction

  // One sweep; ovr_at>0 re-pulses frame_end with a hand on slot 2.
  task automatic sweep(input bit hv, input int hx, input int hy,
                       input int ovr_at, output int lat);
    int n, start;
    wr_t e, o;
    exp_q.delete();
    obs_q.delete();
    done_cnt = 0; ovr_cnt = 0; stray_cnt = 0;
    for (int i = 0; i < 4; i++)
      if (act[i]) exp_q.push_back(model(i, hv, hx, hy));
    @(negedge i_clk);
    i_frame_end  = 1'b1;
    i_hand_valid = hv;
    i_hand_x     = 11'(hx);
    i_hand_y     = 11'(hy);
    @(posedge i_clk);
    #1;
    start = cyc;
    i_frame_end = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      @(posedge i_clk);
      #2;
      n++;
      i_frame_end = (n == ovr_at);
      if (n == ovr_at) begin
        i_hand_valid = 1'b1;
        i_hand_x = bx[2];
        i_hand_y = by[2];
      end
    end
    i_frame_end = 1'b0;
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL sweep_timeout: no o_done within %0d cycles, required 1", n);
    end
    repeat (3) @(posedge i_clk);
    #2;
    lat = done_cyc - start;
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL wr_count: got %0d writes, required %0d",
               obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.idx !== e.idx || o.kill !== e.kill || o.hit !== e.hit ||
          o.miss !== e.miss ||
          (!e.kill && (o.x !== e.x || o.y !== e.y || o.vy !== e.vy))) begin
        failures++;
        $display("FAIL wr_slot%0d: got idx=%0d kill=%0b hit=%0b miss=%0b x=%0d y=%0d vy=%0d, required idx=%0d kill=%0b hit=%0b miss=%0b x=%0d y=%0d vy=%0d",
                 e.idx, o.idx, o.kill, o.hit, o.miss, o.x, o.y, o.vy,
                 e.idx, e.kill, e.hit, e.miss, e.x, e.y, e.vy);
      end
    end
    checks++;
    if (stray_cnt !== 0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL sweep_tail: stray=%0d busy=%0b, required 0 0",
               stray_cnt, o_busy);
    end
  endtask

  task automatic test_reset();
    clear_balls();
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #2;
    checks++;
    if ({o_rd_idx, o_wr_en, o_wr_idx, o_wr_kill, o_wr_x, o_wr_y, o_wr_vy,
         o_hit, o_miss, o_busy, o_done, o_overrun} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_all_inactive();
    int lat;
    clear_balls();
    sweep(1, 10, 10, 0, lat);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL empty_latency: got %0d, required 5", lat);
    end
  endtask

  task automatic test_hit();
    int lat;
    clear_balls();
    set_ball(2, 1, 100, 300, 6, -10);
    sweep(1, 115, 320, 0, lat);
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL hit_latency: got %0d, required 8", lat);
    end
  endtask

  task automatic test_no_hand();
    int lat;
    clear_balls();
    set_ball(2, 1, 100, 300, 6, -10);
    sweep(0, 115, 320, 0, lat);
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL nohand_latency: got %0d, required 8", lat);
    end
  endtask

  task automatic test_miss_ceiling_sat();
    int lat;
    clear_balls();
    set_ball(0, 1, 50, 635, 0, 8);
    set_ball(1, 1, 60, 3, 2, -8);
    set_ball(3, 1, 70, 100, -3, 31);
    sweep(0, 0, 0, 0, lat);
    checks++;
    if (lat !== exp_lat()) begin
      failures++;
      $display("FAIL miss_latency: got %0d, required %0d", lat, exp_lat());
    end
  endtask

  task automatic test_boundaries();
    int lat;
    clear_balls();
    set_ball(0, 1, 200, 200, 0, 0);
    set_ball(1, 1, 400, 629, -5, 10);
    set_ball(2, 1, 200, 199, 0, 0);
    set_ball(3, 1, 5, 300, -8, -32);
    sweep(1, 230, 200, 0, lat);
    checks++;
    if (lat !== 17) begin
      failures++;
      $display("FAIL bound_latency: got %0d, required 17", lat);
    end
  endtask

  task automatic test_overrun();
    int lat;
    clear_balls();
    set_ball(0, 1, 400, 400, 1, 1);
    set_ball(2, 1, 300, 300, -1, -1);
    sweep(1, 100, 100, 2, lat);
    checks++;
    if (ovr_cnt !== 1 || done_cnt !== 1) begin
      failures++;
      $display("FAIL overrun: got overrun=%0d done=%0d, required 1 1",
               ovr_cnt, done_cnt);
    end
    checks++;
    if (lat !== exp_lat()) begin
      failures++;
      $display("FAIL overrun_latency: got %0d, required %0d", lat, exp_lat());
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    clear_balls();
    set_ball(0, 1, 500, 500, 0, 0);
    set_ball(1, 1, 100, 300, 6, -10);
    @(negedge i_clk);
    i_frame_end = 1'b1;
    i_hand_valid = 1'b0;
    @(posedge i_clk);
    #1;
    i_frame_end = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #2;
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_mid: got %0b, required 1", o_busy);
    end
    obs_q.delete();
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_wr_en, o_busy, o_hit, o_miss, o_done, o_overrun, o_rd_idx}
        !== '0) begin
      failures++;
      $display("FAIL async_reset: outputs nonzero, required all 0");
    end
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (obs_q.size() !== 0) begin
      failures++;
      $display("FAIL reset_no_write: got %0d writes, required 0",
               obs_q.size());
    end
    sweep(1, 105, 300, 0, lat);
    checks++;
    if (lat !== exp_lat()) begin
      failures++;
      $display("FAIL post_reset_latency: got %0d, required %0d",
               lat, exp_lat());
    end
  endtask

  initial begin
    test_reset();
    test_all_inactive();
    test_hit();
    test_no_hand();
    test_miss_ceiling_sat();
    test_boundaries();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ball_update_sched.md
Name: ball_update_sched

Overview:
- Per-frame physics/collision sequencer for the fruit-slicing game.
- On each frame-end pulse it walks every ball slot of the game-logic register file in turn. For each active ball it runs a single shared squared-distance multiplier against the latched hand position, then writes back either a kill (hit/miss) or the integrated position and velocity.
- Sits between the hand-tracking predictor output and the ball register file. It replaces per-slot parallel multipliers with one time-shared unit.

Parameters:
- N_BALL, 4, number of ball slots (index width = clog2(N_BALL)).
- COORD_W, 11, coordinate width (unsigned screen pixels).
- VEL_W, 6, velocity width (two's complement).
- HIT_R2, 900, hit threshold on squared distance (radius 30).
- FLOOR_Y, 639, lowest on-screen y; beyond this a falling ball is a miss.
- GRAVITY, 1, added to vy each update.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset.
- i_frame_end  in  1  one-cycle pulse, start of an update sweep.
- i_hand_valid  in  1  hand position valid this frame.
- i_hand_x  in  COORD_W  hand x.
- i_hand_y  in  COORD_W  hand y.
- o_rd_idx  out  clog2(N_BALL)  slot being read (combinational read, data valid same cycle).
- i_ball_active  in  1  slot occupied.
- i_ball_x  in  COORD_W  slot x.
- i_ball_y  in  COORD_W  slot y.
- i_ball_vx  in  VEL_W  slot vx.
- i_ball_vy  in  VEL_W  slot vy.
- o_wr_en  out  1  write-back strobe.
- o_wr_idx  out  clog2(N_BALL)  write-back slot.
- o_wr_kill  out  1  clear slot (active<=0) instead of updating.
- o_wr_x  out  COORD_W  new x.
- o_wr_y  out  COORD_W  new y.
- o_wr_vy  out  VEL_W  new vy (vx unchanged, not written).
- o_hit  out  1  one-cycle pulse, ball sliced.
- o_miss  out  1  one-cycle pulse, ball fell off screen.
- o_busy  out  1  sweep in progress.
- o_done  out  1  one-cycle pulse, sweep finished.
- o_overrun  out  1  one-cycle pulse, frame_end dropped while busy.

Behaviour:
- Reset: i_rst_n, asynchronous, active-low; clock i_clk.
  - All outputs 0.
  - State IDLE, slot index 0, latched hand cleared (valid=0).
- States: IDLE, FETCH, SQX, SQY, DECIDE, DONE.
- IDLE:
  - On i_frame_end, latch hand_valid/x/y, set index=0, go to FETCH.
  - o_busy=1 from the next cycle until DONE inclusive.
- FETCH:
  - o_rd_idx=index.
  - If !i_ball_active: index==N_BALL-1 goes to DONE, else index++ and stay in FETCH. Inactive slots cost 1 cycle.
  - If active: latch ball fields, and compute |dx|=|hand_x-ball_x| and |dy| as COORD_W-bit absolute differences. Go to SQX.
- SQX: shared multiplier computes acc=|dx|*|dx| (2*COORD_W+1 bits).
- SQY: acc += |dy|*|dy|. Same multiplier instance; only one multiply per cycle in the whole block.
- DECIDE: one-cycle o_wr_en, o_wr_idx=index. Outcomes are mutually exclusive, evaluated in this order:
  - Hit: hand_valid && acc<=HIT_R2. o_wr_kill=1, o_hit=1.
  - Otherwise compute x_n=x+sext(vx), y_n=y+sext(vy) (mod 2^COORD_W), vy_n=vy+GRAVITY saturated at +2^(VEL_W-1)-1.
  - Miss: vy[MSB]==0 (falling/still) && y_n>FLOOR_Y. o_wr_kill=1, o_miss=1.
  - Ceiling: vy[MSB]==1 && y_n>FLOOR_Y (upward wrap past 0). Write x_n, y=0, vy=0.
  - Normal: write x_n, y_n, vy_n, kill=0.
  - Then index==N_BALL-1 goes to DONE, else index++ and go to FETCH.
- DONE: o_done pulse, then IDLE.
- Latency: active slot 4 cycles, inactive 1. Worst case sweep 4*N_BALL+1 cycles after the frame_end edge.
- i_frame_end while not IDLE: ignored, and o_overrun pulses for 1 cycle. Sweep continues with the hand latched at its start.
- i_frame_end in the same cycle as DONE: counts as busy and raises overrun; the new sweep starts only from IDLE.
- Hand inputs are only sampled at sweep start. Changes mid-sweep have no effect.
- The ball register file must not be written by anyone else while o_busy=1. This block owns those writes.
- Reset mid-sweep: immediate return to IDLE. Any partial slot is not written (no o_wr_en).

Decomposition:
- game_pkg: COORD_W, VEL_W, N_BALL, HIT_R2, FLOOR_Y, state enum sched_state_t, and the struct ball_t {active,x,y,vx,vy}.
- One sub-module: sq_dist_mac, a single multiplier plus accumulator with clear/accumulate control. It is the shared resource this scheduler sequences.

Test Plan:
- All 4 slots inactive, frame_end → o_done exactly 5 cycles after the pulse; no o_wr_en.
- Slot 2 active (x=100,y=300,vx=6,vy=-10), hand (115,320) valid → dist²=625: wr_kill, idx=2, o_hit=1, done at cycle 8.
- Same ball, hand_valid=0 → write x=106, y=290, vy=-9; no hit or miss.
- Ball y=635, vy=+8 → y_n=643 > 639: wr_kill, o_miss=1. Ball y=3, vy=-8 → y_n wraps: write y=0, vy=0, no miss. Ball vy=+31 → vy stays 31.
- Second frame_end 3 cycles into a sweep → o_overrun pulse; single o_done; slot results use the first hand sample.
- Assert i_rst_n low during SQY → outputs 0 asynchronously, no write strobe; next frame_end performs a full clean sweep.
